// File: rtl/xil_7s_dphy_clk_lane_ctrl.sv
// D-PHY HS clock-lane receive sequencer: LP state tracking, Tclk-settle,
// byte-clock divider clear and ISERDES reset release.
module xil_7s_dphy_clk_lane_ctrl #(
    parameter int CNT_W          = 8,
    parameter int SETTLE_CYC     = 24,
    parameter int DIV_RST_CYC    = 4,
    parameter int SERDES_RST_CYC = 8,
    parameter int RQST_TO_CYC    = 200
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       enable_i,
    input  logic       lp_clk_p_i,
    input  logic       lp_clk_n_i,
    output logic       bufr_clr_o,
    output logic       serdes_rst_o,
    output logic       hs_clk_active_o,
    output logic [2:0] state_o,
    output logic       err_o
);

    typedef enum logic [2:0] {
        STOP     = 3'd0,
        HS_RQST  = 3'd1,
        SETTLE   = 3'd2,
        DIV_RST  = 3'd3,
        SRDS_RST = 3'd4,
        HS_ACT   = 3'd5,
        ERR      = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] RQST_LD   = CNT_W'(RQST_TO_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] DIV_LD    = CNT_W'(DIV_RST_CYC - 1);
    localparam logic [CNT_W-1:0] SRDS_LD   = CNT_W'(SERDES_RST_CYC - 1);

    logic [1:0]       lp_s1, lp_s2, lp_smp, lp_st;
    state_t           state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             err_n, was_err;
    logic             cnt_zero, lp_in_hs;

    // {P,N} synchronizer, then accept a value only once it is seen twice
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lp_s1  <= 2'b11;
            lp_s2  <= 2'b11;
            lp_smp <= 2'b11;
            lp_st  <= 2'b11;
        end else begin
            lp_s1  <= {lp_clk_p_i, lp_clk_n_i};
            lp_s2  <= lp_s1;
            lp_smp <= lp_s2;
            if (lp_s2 == lp_smp) lp_st <= lp_s2;
        end
    end

    assign cnt_zero = (cnt_q == '0);
    assign lp_in_hs = (lp_st == 2'b00);

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        err_n   = 1'b0;
        if (!enable_i) begin
            state_n = STOP;
        end else begin
            unique case (state_q)
                STOP: begin
                    if (lp_st == 2'b01) begin
                        state_n = HS_RQST;
                        cnt_n   = RQST_LD;
                    end else if (lp_st == 2'b10 || lp_st == 2'b00) begin
                        state_n = ERR;
                        err_n   = !was_err;
                    end
                end
                HS_RQST: begin
                    if (lp_st == 2'b00) begin
                        state_n = SETTLE;
                        cnt_n   = SETTLE_LD;
                    end else if (lp_st == 2'b11) begin
                        state_n = STOP;
                    end else if (lp_st == 2'b10 || cnt_zero) begin
                        state_n = ERR;
                        err_n   = 1'b1;
                    end else begin
                        cnt_n = cnt_q - 1'b1;
                    end
                end
                SETTLE: begin
                    if (!lp_in_hs) begin
                        state_n = STOP;
                    end else if (cnt_zero) begin
                        state_n = DIV_RST;
                        cnt_n   = DIV_LD;
                    end else begin
                        cnt_n = cnt_q - 1'b1;
                    end
                end
                DIV_RST: begin
                    if (!lp_in_hs) begin
                        state_n = STOP;
                    end else if (cnt_zero) begin
                        state_n = SRDS_RST;
                        cnt_n   = SRDS_LD;
                    end else begin
                        cnt_n = cnt_q - 1'b1;
                    end
                end
                SRDS_RST: begin
                    if (!lp_in_hs) begin
                        state_n = STOP;
                    end else if (cnt_zero) begin
                        state_n = HS_ACT;
                    end else begin
                        cnt_n = cnt_q - 1'b1;
                    end
                end
                HS_ACT: begin
                    if (lp_st == 2'b11) state_n = STOP;
                end
                ERR: begin
                    if (lp_st == 2'b11) state_n = STOP;
                end
                default: state_n = STOP;
            endcase
        end
    end

    // outputs decoded from the next state so they move with the state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= STOP;
            cnt_q           <= '0;
            was_err         <= 1'b0;
            bufr_clr_o      <= 1'b1;
            serdes_rst_o    <= 1'b1;
            hs_clk_active_o <= 1'b0;
            err_o           <= 1'b0;
        end else begin
            state_q         <= state_n;
            cnt_q           <= cnt_n;
            was_err         <= (state_q == ERR);
            bufr_clr_o      <= !(state_n == SRDS_RST || state_n == HS_ACT);
            serdes_rst_o    <= (state_n != HS_ACT);
            hs_clk_active_o <= (state_n == HS_ACT);
            err_o           <= err_n;
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_xil_7s_dphy_clk_lane_ctrl.sv
// Scoreboard bench for the D-PHY clock-lane sequencer: expected output
// vectors and their hold lengths are queued, a monitor checks each change.
module tb_xil_7s_dphy_clk_lane_ctrl;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       enable_i;
    logic       lp_clk_p_i;
    logic       lp_clk_n_i;
    logic       bufr_clr_o;
    logic       serdes_rst_o;
    logic       hs_clk_active_o;
    logic [2:0] state_o;
    logic       err_o;

    xil_7s_dphy_clk_lane_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .enable_i       (enable_i),
        .lp_clk_p_i     (lp_clk_p_i),
        .lp_clk_n_i     (lp_clk_n_i),
        .bufr_clr_o     (bufr_clr_o),
        .serdes_rst_o   (serdes_rst_o),
        .hs_clk_active_o(hs_clk_active_o),
        .state_o        (state_o),
        .err_o          (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] vec;
        int         len;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;
    logic mon_on = 1'b0;

    // vec = {state, bufr_clr, serdes_rst, hs_active, err}; len = cycles held, -1 = any
    task automatic push(input logic [2:0] st, input logic b, input logic s,
                        input logic h, input logic e, input int len);
        exp_t x;
        x.vec = {st, b, s, h, e};
        x.len = len;
        exp_q.push_back(x);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic lane(input logic [1:0] pn);
        lp_clk_p_i = pn[1];
        lp_clk_n_i = pn[0];
    endtask

    initial begin : monitor
        logic [6:0] cur, prev;
        bit         first;
        int         run, pend_len, ev;
        exp_t       e;
        first    = 1'b1;
        run      = 0;
        pend_len = -1;
        ev       = 0;
        prev     = '0;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                cur = {state_o, bufr_clr_o, serdes_rst_o, hs_clk_active_o, err_o};
                run++;
                if (first || cur != prev) begin
                    if (!first && pend_len >= 0) begin
                        checks++;
                        if (run != pend_len) begin
                            fails++;
                            $display("FAIL len ev%0d: held %0d cycles, required %0d",
                                     ev - 1, run, pend_len);
                        end
                    end
                    checks++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        pend_len = -1;
                        $display("FAIL unexpected ev%0d: got %b, nothing queued", ev, cur);
                    end else begin
                        e = exp_q.pop_front();
                        if (cur !== e.vec) begin
                            fails++;
                            $display("FAIL vec ev%0d: got %b, required %b", ev, cur, e.vec);
                        end
                        pend_len = e.len;
                    end
                    ev++;
                    run   = 0;
                    prev  = cur;
                    first = 1'b0;
                end
            end
        end
    end

    initial begin : stim
        int wait_cyc;
        rst_i    = 1'b1;
        enable_i = 1'b1;
        lane(2'b11);
        cyc(3);
        push(3'd0, 1, 1, 0, 0, -1);
        rst_i  = 1'b0;
        mon_on = 1'b1;

        // idle LP-11: no change expected
        cyc(100);

        // full HS entry then back to LP-11
        push(3'd1, 1, 1, 0, 0, 20);
        push(3'd2, 1, 1, 0, 0, 24);
        push(3'd3, 1, 1, 0, 0, 4);
        push(3'd4, 0, 1, 0, 0, 8);
        push(3'd5, 0, 0, 1, 0, 24);
        push(3'd0, 1, 1, 0, 0, -1);
        lane(2'b01);
        cyc(20);
        lane(2'b00);
        cyc(60);
        lane(2'b11);
        cyc(20);

        // request timeout
        push(3'd1, 1, 1, 0, 0, 200);
        push(3'd6, 1, 1, 0, 1, 1);
        push(3'd6, 1, 1, 0, 0, 99);
        push(3'd0, 1, 1, 0, 0, -1);
        lane(2'b01);
        cyc(300);
        lane(2'b11);
        cyc(20);

        // illegal 11->10, then a one-cycle glitch that must be filtered
        push(3'd6, 1, 1, 0, 1, 1);
        push(3'd6, 1, 1, 0, 0, -1);
        push(3'd0, 1, 1, 0, 0, -1);
        lane(2'b10);
        cyc(20);
        lane(2'b11);
        cyc(20);
        lane(2'b01);
        cyc(1);
        lane(2'b11);
        cyc(20);

        // reset during SRDS_RST
        push(3'd1, 1, 1, 0, 0, 10);
        push(3'd2, 1, 1, 0, 0, 24);
        push(3'd3, 1, 1, 0, 0, 4);
        push(3'd4, 0, 1, 0, 0, 4);
        push(3'd0, 1, 1, 0, 0, -1);
        lane(2'b01);
        cyc(10);
        lane(2'b00);
        cyc(36);
        rst_i = 1'b1;
        lane(2'b11);
        cyc(1);
        rst_i = 1'b0;
        cyc(20);

        // enable dropped during SETTLE
        push(3'd1, 1, 1, 0, 0, 10);
        push(3'd2, 1, 1, 0, 0, 11);
        push(3'd0, 1, 1, 0, 0, -1);
        lane(2'b01);
        cyc(10);
        lane(2'b00);
        cyc(15);
        enable_i = 1'b0;
        lane(2'b11);
        cyc(10);
        enable_i = 1'b1;
        cyc(20);

        wait_cyc = 0;
        while (exp_q.size() != 0 && wait_cyc < 200) begin
            cyc(1);
            wait_cyc++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d events outstanding, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
